// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encoding and default bus widths.
package im_loader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_PUBLISH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/im_load_checksum.sv
// Running modulo-2**DATA_WIDTH sum of the words written during one load.
// Instantiated by im_program_loader only when LOADER_CHECKSUM_EN is defined.
module im_load_checksum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_sum
);

  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_sum <= '0;
    end else if (i_enable) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/im_program_loader.sv
// Copies a program image from a word-addressed source into the IM write port, then publishes the IM offset.
// Optional feature macro: LOADER_CHECKSUM_EN adds a checksum output over the words written.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start; latches src/dst/count on start
// ST_CHECK   | zero-count shortcut or range check of dst_base + count
// ST_REQ     | one-cycle source read request for word i
// ST_WAIT    | holding until the source strobes valid; captures data
// ST_WRITE   | one-cycle IM write of the captured word; advances i
// ST_PUBLISH | drives IM_offset = dst_base with FLAG_IMoffset
// ST_DONE    | one-cycle done pulse
module im_program_loader
  import im_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] src_base,
  input  logic [DATA_WIDTH-1:0] dst_base,
  input  logic [DATA_WIDTH-1:0] word_count,
  output logic                  src_rd_req,
  output logic [DATA_WIDTH-1:0] src_rd_addr,
  input  logic                  src_rd_valid,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] IM_offset,
  output logic                  FLAG_IMoffset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH:0]   IM_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] IM_DEPTH_W = {{(DATA_WIDTH-ADDR_WIDTH-1){1'b0}}, IM_DEPTH};

  state_e                r_state;
  state_e                w_next;
  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_offset;

  logic [ADDR_WIDTH:0]   w_end;
  logic                  w_range_ok;
  logic                  w_last;

  // Bounding dst and count first keeps the (ADDR_WIDTH+1)-bit end sum from overflowing.
  assign w_end      = r_dst[ADDR_WIDTH:0] + r_cnt[ADDR_WIDTH:0];
  assign w_range_ok = (r_dst < IM_DEPTH_W) && (r_cnt <= IM_DEPTH_W) && (w_end <= IM_DEPTH);
  assign w_last     = (r_idx == (r_cnt - DATA_WIDTH'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_offset <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src <= src_base;
            r_dst <= dst_base;
            r_cnt <= word_count;
            r_idx <= '0;
          end
        end
        ST_WAIT: begin
          if (src_rd_valid) begin
            r_data <= src_rd_data;
          end
        end
        ST_WRITE:   r_idx    <= r_idx + DATA_WIDTH'(1);
        ST_PUBLISH: r_offset <= r_dst;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_cnt == '0)      w_next = ST_DONE;
        else if (!w_range_ok) w_next = ST_IDLE;
        else                  w_next = ST_REQ;
      end
      ST_REQ:     w_next = ST_WAIT;
      ST_WAIT: begin
        if (src_rd_valid) w_next = ST_WRITE;
      end
      ST_WRITE:   w_next = w_last ? ST_PUBLISH : ST_REQ;
      ST_PUBLISH: w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  assign src_rd_req    = (r_state == ST_REQ);
  assign src_rd_addr   = src_rd_req ? (r_src + r_idx) : '0;
  assign write         = (r_state == ST_WRITE);
  assign write_addr    = write ? (r_dst + r_idx) : '0;
  assign write_data    = write ? r_data : '0;
  assign FLAG_IMoffset = (r_state == ST_PUBLISH);
  // The new offset must already be visible in the strobe cycle, before r_offset updates.
  assign IM_offset     = FLAG_IMoffset ? r_dst : r_offset;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign error         = (r_state == ST_CHECK) && (r_cnt != '0) && !w_range_ok;

`ifdef LOADER_CHECKSUM_EN
  logic w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;

  im_load_checksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_enable (write),
    .i_data   (r_data),
    .o_sum    (checksum)
  );
`endif

endmodule

// File: tb/tb_im_program_loader.sv
// Self-checking bench for im_program_loader: randomized source data and load parameters
// against a queue-based reference of the expected reads, writes, offset and timing.
module tb_im_program_loader;

  localparam int DW = 32;
  localparam int AW = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] src_base, dst_base, word_count;
  logic          src_rd_req;
  logic [DW-1:0] src_rd_addr;
  logic          src_rd_valid;
  logic [DW-1:0] src_rd_data;
  logic          write;
  logic [DW-1:0] write_addr, write_data, IM_offset;
  logic          FLAG_IMoffset, busy, done, error;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  im_program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .src_base      (src_base),
    .dst_base      (dst_base),
    .word_count    (word_count),
    .src_rd_req    (src_rd_req),
    .src_rd_addr   (src_rd_addr),
    .src_rd_valid  (src_rd_valid),
    .src_rd_data   (src_rd_data),
    .write         (write),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .IM_offset     (IM_offset),
    .FLAG_IMoffset (FLAG_IMoffset),
    .busy          (busy),
    .done          (done),
    .error         (error)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;

  always @(posedge clock) cyc <= cyc + 1;

  logic [DW-1:0] src_mem [256];
  logic [DW-1:0] got_waddr[$], got_wdata[$], got_raddr[$];
  logic [DW-1:0] exp_waddr[$], exp_wdata[$], exp_raddr[$];
  logic [DW-1:0] flag_off, done_cks, exp_cks, resp_a;
  int            nflag, ndone, nerr, multi_wr, done_cyc, err_cyc, start_cyc;
  int            exp_done_lat;
  bit            exp_err, timed_out, prev_wr;

  // Source memory: answers each request 'lat' cycles later with a one-cycle valid.
  initial begin
    src_rd_valid = 1'b0;
    src_rd_data  = '0;
    forever begin
      @(negedge clock);
      if (src_rd_req === 1'b1) begin
        resp_a = src_rd_addr;
        repeat (lat) @(posedge clock);
        #1;
        src_rd_valid = 1'b1;
        src_rd_data  = src_mem[resp_a[7:0]];
        @(posedge clock);
        #1;
        src_rd_valid = 1'b0;
        src_rd_data  = $urandom;
      end
    end
  end

  initial begin
    prev_wr = 1'b0;
    forever begin
      @(negedge clock);
      if (write === 1'b1) begin
        got_waddr.push_back(write_addr);
        got_wdata.push_back(write_data);
        if (prev_wr) multi_wr++;
      end
      prev_wr = (write === 1'b1);
      if (src_rd_req === 1'b1) got_raddr.push_back(src_rd_addr);
      if (FLAG_IMoffset === 1'b1) begin
        nflag++;
        flag_off = IM_offset;
      end
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
`ifdef LOADER_CHECKSUM_EN
        done_cks = checksum;
`endif
      end
      if (error === 1'b1) begin
        nerr++;
        err_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    got_waddr.delete(); got_wdata.delete(); got_raddr.delete();
    nflag = 0; ndone = 0; nerr = 0; multi_wr = 0;
    done_cyc = -1; err_cyc = -1; flag_off = '0; done_cks = '0;
  endtask

  // Reference: what a load must do, from the request parameters alone.
  task automatic model_load(input logic [DW-1:0] s, input logic [DW-1:0] d,
                            input logic [DW-1:0] n, input int l);
    longint end_w;
    logic [DW-1:0] a;
    exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete();
    exp_cks = '0;
    end_w   = longint'(d) + longint'(n);
    exp_err = (n != 0) && (end_w > (longint'(1) << AW));
    if (!exp_err) begin
      for (longint i = 0; i < longint'(n); i++) begin
        a = s + DW'(i);
        exp_raddr.push_back(a);
        exp_waddr.push_back(d + DW'(i));
        exp_wdata.push_back(src_mem[a[7:0]]);
        exp_cks = exp_cks + src_mem[a[7:0]];
      end
    end
    exp_done_lat = (n == 0) ? 2 : int'(n) * (l + 2) + 3;
  endtask

  task automatic run_load(input logic [DW-1:0] s, input logic [DW-1:0] d,
                          input logic [DW-1:0] n, input int l, input bit stray);
    bit stray_sent;
    stray_sent = 1'b0;
    lat = l;
    clear_mon();
    model_load(s, d, n, l);
    @(posedge clock); #1;
    src_base = s; dst_base = d; word_count = n; start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (ndone != 0 || nerr != 0) begin
        timed_out = 1'b0;
        break;
      end
      if (stray && !stray_sent && got_raddr.size() == 2) begin
        start = 1'b1; src_base = $urandom; dst_base = $urandom_range(0, 100); word_count = 1;
        stray_sent = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL load_timeout: no done/error within bound, src=%h dst=%h cnt=%0d", s, d, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({src_rd_req, src_rd_addr, write, write_addr, write_data, IM_offset,
         FLAG_IMoffset, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b raddr=%h wr=%b waddr=%h wdata=%h off=%h flag=%b busy=%b done=%b err=%b, expected all 0",
               src_rd_req, src_rd_addr, write, write_addr, write_data, IM_offset, FLAG_IMoffset, busy, done, error);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic_copy();
    for (int i = 0; i < 4; i++) src_mem[8'h40 + i] = 32'hA000_0000 | $urandom_range(0, 32'hFFFF);
    run_load(32'h40, 32'h10, 4, 1, 1'b0);
    checks++;
    if (got_waddr.size() != 4) begin
      errors++;
      $display("FAIL basic_nwrites: got %0d expected 4", got_waddr.size());
    end
    for (int i = 0; i < 4 && i < got_waddr.size(); i++) begin
      checks++;
      if (got_waddr[i] !== 32'h10 + i || got_wdata[i] !== exp_wdata[i]) begin
        errors++;
        $display("FAIL basic_write[%0d]: got %h/%h expected %h/%h", i, got_waddr[i], got_wdata[i], 32'h10 + i, exp_wdata[i]);
      end
    end
    checks++;
    if (nflag != 1 || flag_off !== 32'h10) begin
      errors++;
      $display("FAIL basic_offset: got flags=%0d offset=%h expected 1/00000010", nflag, flag_off);
    end
    checks++;
    if (ndone != 1 || done_cyc - start_cyc != 15) begin
      errors++;
      $display("FAIL basic_done_latency: got done=%0d at +%0d expected 1 at +15", ndone, done_cyc - start_cyc);
    end
    checks++;
    if (IM_offset !== 32'h10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got offset=%h busy=%b expected 00000010/0", IM_offset, busy);
    end
  endtask

  task automatic test_zero_count();
    run_load(32'h77, 32'h300, 0, 1, 1'b0);
    checks++;
    if (ndone != 1 || done_cyc - start_cyc != 2) begin
      errors++;
      $display("FAIL zero_done: got done=%0d at +%0d expected 1 at +2", ndone, done_cyc - start_cyc);
    end
    checks++;
    if (got_waddr.size() != 0 || got_raddr.size() != 0 || nflag != 0 || nerr != 0) begin
      errors++;
      $display("FAIL zero_activity: got writes=%0d reqs=%0d flags=%0d errs=%0d expected all 0",
               got_waddr.size(), got_raddr.size(), nflag, nerr);
    end
  endtask

  task automatic test_range_edges();
    run_load(32'h0, 32'd2046, 3, 1, 1'b0);
    checks++;
    if (nerr != 1 || err_cyc - start_cyc != 1 || ndone != 0) begin
      errors++;
      $display("FAIL range_reject: got err=%0d at +%0d done=%0d expected 1 at +1, 0", nerr, err_cyc - start_cyc, ndone);
    end
    checks++;
    if (got_waddr.size() != 0 || got_raddr.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_reject_quiet: got writes=%0d reqs=%0d busy=%b expected 0/0/0", got_waddr.size(), got_raddr.size(), busy);
    end
    run_load(32'h8, 32'd2045, 3, 1, 1'b0);
    checks++;
    if (nerr != 0 || ndone != 1 || got_waddr.size() != 3) begin
      errors++;
      $display("FAIL range_accept: got err=%0d done=%0d writes=%0d expected 0/1/3", nerr, ndone, got_waddr.size());
    end
    for (int i = 0; i < 3 && i < got_waddr.size(); i++) begin
      checks++;
      if (got_waddr[i] !== 32'd2045 + i || got_wdata[i] !== exp_wdata[i]) begin
        errors++;
        $display("FAIL range_write[%0d]: got %h/%h expected %h/%h", i, got_waddr[i], got_wdata[i], 32'd2045 + i, exp_wdata[i]);
      end
    end
  endtask

  task automatic test_slow_source();
    run_load(32'hC0, 32'h400, 3, 5, 1'b1);
    checks++;
    if (got_waddr.size() != 3 || multi_wr != 0) begin
      errors++;
      $display("FAIL slow_writes: got writes=%0d back-to-back=%0d expected 3/0", got_waddr.size(), multi_wr);
    end
    for (int i = 0; i < 3 && i < got_waddr.size(); i++) begin
      checks++;
      if (got_waddr[i] !== exp_waddr[i] || got_wdata[i] !== exp_wdata[i]) begin
        errors++;
        $display("FAIL slow_write[%0d]: got %h/%h expected %h/%h", i, got_waddr[i], got_wdata[i], exp_waddr[i], exp_wdata[i]);
      end
    end
    checks++;
    if (ndone != 1 || done_cyc - start_cyc != exp_done_lat || nflag != 1 || flag_off !== 32'h400) begin
      errors++;
      $display("FAIL slow_finish: got done=%0d at +%0d flags=%0d off=%h expected 1 at +%0d, 1, 00000400",
               ndone, done_cyc - start_cyc, nflag, flag_off, exp_done_lat);
    end
  endtask

  task automatic test_reset_midload();
    bit reached;
    lat = 5;
    clear_mon();
    reached = 1'b0;
    @(posedge clock); #1;
    src_base = 32'h80; dst_base = 32'h100; word_count = 4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (got_raddr.size() == 2) begin
        reached = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midload_reach: got reqs=%0d expected 2", got_raddr.size());
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({src_rd_req, src_rd_addr, write, write_addr, write_data, IM_offset,
         FLAG_IMoffset, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL midload_reset_outputs: got busy=%b wr=%b off=%h req=%b expected all 0", busy, write, IM_offset, src_rd_req);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (got_waddr.size() != 1 || ndone != 0 || nflag != 0) begin
      errors++;
      $display("FAIL midload_abort: got writes=%0d done=%0d flags=%0d expected 1/0/0", got_waddr.size(), ndone, nflag);
    end
    run_load(32'h20, 32'h30, 3, 1, 1'b0);
    checks++;
    if (got_waddr.size() != 3 || ndone != 1 || nflag != 1 || flag_off !== 32'h30) begin
      errors++;
      $display("FAIL midload_restart: got writes=%0d done=%0d flags=%0d off=%h expected 3/1/1/00000030",
               got_waddr.size(), ndone, nflag, flag_off);
    end
    for (int i = 0; i < 3 && i < got_waddr.size(); i++) begin
      checks++;
      if (got_waddr[i] !== exp_waddr[i] || got_wdata[i] !== exp_wdata[i]) begin
        errors++;
        $display("FAIL midload_restart_write[%0d]: got %h/%h expected %h/%h", i, got_waddr[i], got_wdata[i], exp_waddr[i], exp_wdata[i]);
      end
    end
  endtask

  task automatic test_random_loads();
    logic [DW-1:0] s, d, n;
    int l;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
      s = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 3)) : $urandom;
      d = ($urandom_range(0, 2) == 0) ? (32'd2048 - $urandom_range(0, 7)) : $urandom_range(0, 2040);
      n = $urandom_range(0, 7);
      l = $urandom_range(1, 4);
      run_load(s, d, n, l, 1'b0);
      checks++;
      if (got_waddr.size() != exp_waddr.size() || got_raddr.size() != exp_raddr.size()) begin
        errors++;
        $display("FAIL rand%0d_counts: got writes=%0d reqs=%0d expected %0d/%0d",
                 t, got_waddr.size(), got_raddr.size(), exp_waddr.size(), exp_raddr.size());
      end
      for (int i = 0; i < exp_waddr.size() && i < got_waddr.size() && i < got_raddr.size(); i++) begin
        checks++;
        if (got_raddr[i] !== exp_raddr[i] || got_waddr[i] !== exp_waddr[i] || got_wdata[i] !== exp_wdata[i]) begin
          errors++;
          $display("FAIL rand%0d_word[%0d]: got raddr=%h waddr=%h wdata=%h expected %h/%h/%h",
                   t, i, got_raddr[i], got_waddr[i], got_wdata[i], exp_raddr[i], exp_waddr[i], exp_wdata[i]);
        end
      end
      checks++;
      if (exp_err) begin
        if (nerr != 1 || err_cyc - start_cyc != 1 || ndone != 0 || nflag != 0) begin
          errors++;
          $display("FAIL rand%0d_reject: got err=%0d at +%0d done=%0d flags=%0d expected 1 at +1, 0, 0",
                   t, nerr, err_cyc - start_cyc, ndone, nflag);
        end
      end else begin
        if (nerr != 0 || ndone != 1 || done_cyc - start_cyc != exp_done_lat ||
            nflag != (n != 0 ? 1 : 0) || (n != 0 && flag_off !== d)) begin
          errors++;
          $display("FAIL rand%0d_finish: got err=%0d done=%0d at +%0d flags=%0d off=%h expected 0, 1 at +%0d, off=%h",
                   t, nerr, ndone, done_cyc - start_cyc, nflag, flag_off, exp_done_lat, d);
        end
      end
`ifdef LOADER_CHECKSUM_EN
      if (!exp_err) begin
        checks++;
        if (done_cks !== exp_cks) begin
          errors++;
          $display("FAIL rand%0d_checksum: got %h expected %h", t, done_cks, exp_cks);
        end
      end
`endif
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    src_mem[8'h50] = 32'hFFFF_FFFF;
    src_mem[8'h51] = 32'h0000_0002;
    run_load(32'h50, 32'h200, 2, 1, 1'b0);
    checks++;
    if (ndone != 1 || done_cks !== 32'h0000_0001) begin
      errors++;
      $display("FAIL checksum_wrap: got done=%0d checksum=%h expected 1/00000001", ndone, done_cks);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0;
    src_base = '0; dst_base = '0; word_count = '0;
    for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
    clear_mon();
    test_reset();
    test_basic_copy();
    test_zero_count();
    test_range_edges();
    test_slow_source();
    test_reset_midload();
    test_random_loads();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
